// File: rtl/pc_sequencer_pkg.sv
// Shared types and helpers for the PC sequencer: FSM state encoding,
// instruction size and the redirect-target alignment check.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2,
        TRAP  = 2'd3
    } pc_seq_state_e;

    localparam int InstrBytes = 4;

    // No compressed ISA, so any nonzero low bit is a misaligned target.
    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between the PC sequencer and imem.
interface pc_sequencer_if #(
    parameter int AddressWidth = 10
);
    logic                    imem_req_o;
    logic [AddressWidth-1:0] imem_addr_o;
    logic                    imem_ready_i;

    modport master (output imem_req_o, output imem_addr_o, input imem_ready_i);
    modport slave  (input imem_req_o, input imem_addr_o, output imem_ready_i);
endinterface

// File: rtl/adder.sv
// Plain modulo-2^Width adder.
module adder #(
    parameter int Width = 32
) (
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    output logic [Width-1:0] sum
);
    assign sum = a + b;
endmodule

// File: rtl/mux2.sv
// Two-input mux: y = sel ? d1 : d0.
module mux2 #(
    parameter int Width = 32
) (
    input  logic             sel,
    input  logic [Width-1:0] d0,
    input  logic [Width-1:0] d1,
    output logic [Width-1:0] y
);
    assign y = sel ? d1 : d0;
endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC owner for the single-cycle core: fetch handshake, PC
// advance/redirect, halt/resume, misaligned-redirect trap, retire counter.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                    AddressWidth = 10,
    parameter logic [AddressWidth-1:0] ResetVector = '0,
    parameter int                    CountWidth   = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    stall_i,
    input  logic                    redirect_i,
    input  logic [AddressWidth-1:0] redirect_target_i,
    input  logic                    halt_i,
    input  logic                    resume_i,
    pc_sequencer_if.master          imem,
    output logic [AddressWidth-1:0] pc_o,
    output logic [AddressWidth-1:0] pc_plus4_o,
    output logic                    instr_valid_o,
    output logic                    misalign_o,
    output logic [AddressWidth-1:0] trap_target_o,
    output logic [CountWidth-1:0]   instret_o
);

    pc_seq_state_e           state_q, state_d;
    logic [AddressWidth-1:0] pc_q, pc_plus4, pc_next, trap_target_q;
    logic [CountWidth-1:0]   instret_q;
    logic                    misalign_q;
    logic                    retire, trap_take, retire_ok;

    adder #(.Width(AddressWidth)) u_pc_plus4 (
        .a   (pc_q),
        .b   (AddressWidth'(InstrBytes)),
        .sum (pc_plus4)
    );

    mux2 #(.Width(AddressWidth)) u_next_pc (
        .sel (redirect_i),
        .d0  (pc_plus4),
        .d1  (redirect_target_i),
        .y   (pc_next)
    );

    // Without a retire the branch unit re-evaluates, so redirect/halt only matter here.
    assign retire    = (state_q == FETCH) && imem.imem_ready_i && !stall_i;
    assign trap_take = retire && redirect_i && !is_aligned(redirect_target_i[1:0]);
    assign retire_ok = retire && !trap_take;

    always_comb begin
        state_d           = state_q;
        imem.imem_req_o   = 1'b0;
        instr_valid_o     = 1'b0;
        case (state_q)
            BOOT:  state_d = FETCH;
            FETCH: begin
                imem.imem_req_o = 1'b1;
                instr_valid_o   = imem.imem_ready_i;
                if (trap_take)              state_d = TRAP;
                else if (retire && halt_i)  state_d = HALT;
            end
            HALT:  if (resume_i) state_d = FETCH;
            TRAP:  state_d = TRAP;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= BOOT;
            pc_q          <= ResetVector;
            instret_q     <= '0;
            misalign_q    <= 1'b0;
            trap_target_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire_ok) begin
                pc_q      <= pc_next;
                instret_q <= instret_q + CountWidth'(1);
            end
            if (trap_take) begin
                misalign_q    <= 1'b1;
                trap_target_q <= redirect_target_i;
            end
        end
    end

    assign imem.imem_addr_o = pc_q;
    assign pc_o             = pc_q;
    assign pc_plus4_o       = pc_plus4;
    assign misalign_o       = misalign_q;
    assign trap_target_o    = trap_target_q;
    assign instret_o        = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: stimulus pushes expected fetch records,
// a negedge monitor pops one per presented instruction and compares.
module tb_pc_sequencer;
    localparam int AW = 10;
    localparam int CW = 32;

    typedef struct {
        logic [AW-1:0] pc;
        logic [AW-1:0] pc4;
        logic [CW-1:0] instret;
    } exp_t;

    logic          clk, rst_n;
    logic          stall, redirect, halt, resume;
    logic [AW-1:0] target;
    logic [AW-1:0] pc, pc_plus4, trap_target;
    logic          instr_valid, misalign;
    logic [CW-1:0] instret;

    int checks = 0;
    int passes = 0;
    exp_t exp_q[$];

    pc_sequencer_if #(.AddressWidth(AW)) imem_bus ();

    pc_sequencer #(.AddressWidth(AW), .ResetVector('0), .CountWidth(CW)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .stall_i           (stall),
        .redirect_i        (redirect),
        .redirect_target_i (target),
        .halt_i            (halt),
        .resume_i          (resume),
        .imem              (imem_bus),
        .pc_o              (pc),
        .pc_plus4_o        (pc_plus4),
        .instr_valid_o     (instr_valid),
        .misalign_o        (misalign),
        .trap_target_o     (trap_target),
        .instret_o         (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act === want) passes++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic stl, input logic rd,
                         input logic [AW-1:0] tgt, input logic hlt, input logic rsm);
        imem_bus.imem_ready_i = rdy;
        stall    = stl;
        redirect = rd;
        target   = tgt;
        halt     = hlt;
        resume   = rsm;
    endtask

    task automatic expect_fetch(input logic [AW-1:0] p, input logic [CW-1:0] n);
        exp_t e;
        e.pc = p;
        e.pc4 = p + AW'(4);
        e.instret = n;
        exp_q.push_back(e);
    endtask

    // Monitor: every presented instruction must match the oldest expectation.
    always @(negedge clk) begin
        if (instr_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", {31'd0, instr_valid}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("imem_addr", 32'(imem_bus.imem_addr_o), 32'(e.pc));
                chk("req",       {31'd0, imem_bus.imem_req_o}, 32'd1);
                chk("pc",        32'(pc), 32'(e.pc));
                chk("pc_plus4",  32'(pc_plus4), 32'(e.pc4));
                chk("instret",   instret, e.instret);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        #2;
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_req", {31'd0, imem_bus.imem_req_o}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_trap_target", 32'(trap_target), 32'd0);
        chk("rst_pc_plus4", 32'(pc_plus4), 32'h4);

        tick();
        rst_n = 1'b1;
        #1 chk("boot_req", {31'd0, imem_bus.imem_req_o}, 32'd0);

        // Sequential fetch from reset vector.
        tick(); expect_fetch(10'h000, 0);
        tick(); expect_fetch(10'h004, 1);
        tick(); expect_fetch(10'h008, 2);
        tick(); chk("instret_after3", instret, 32'd3); expect_fetch(10'h00C, 3);

        // Taken branch at 0x010, first cycle stalled.
        tick(); expect_fetch(10'h010, 4); drive(1'b1, 1'b1, 1'b1, 10'h040, 1'b0, 1'b0);
        tick(); expect_fetch(10'h010, 4); drive(1'b1, 1'b0, 1'b1, 10'h040, 1'b0, 1'b0);
        tick(); expect_fetch(10'h040, 5); drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Wrap at top of address space.
        tick(); expect_fetch(10'h044, 6); drive(1'b1, 1'b0, 1'b1, 10'h3FC, 1'b0, 1'b0);
        tick(); expect_fetch(10'h3FC, 7); drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick(); expect_fetch(10'h000, 8); drive(1'b1, 1'b0, 1'b1, 10'h020, 1'b0, 1'b0);

        // Halt with simultaneous redirect at 0x020.
        tick(); expect_fetch(10'h020, 9); drive(1'b1, 1'b0, 1'b1, 10'h080, 1'b1, 1'b0);
        tick(); drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("halt_req", {31'd0, imem_bus.imem_req_o}, 32'd0);
        chk("halt_valid", {31'd0, instr_valid}, 32'd0);
        chk("halt_pc", 32'(pc), 32'h080);
        chk("halt_instret", instret, 32'd10);
        for (int i = 0; i < 4; i++) tick();
        chk("halt_pc_hold", 32'(pc), 32'h080);
        resume = 1'b1;
        tick(); resume = 1'b0; expect_fetch(10'h080, 10);
        tick(); resume = 1'b1; expect_fetch(10'h084, 11);
        tick(); resume = 1'b0; expect_fetch(10'h088, 12);
        drive(1'b1, 1'b0, 1'b1, 10'h030, 1'b0, 1'b0);

        // Misaligned redirect wins over halt.
        tick(); expect_fetch(10'h030, 13); drive(1'b1, 1'b0, 1'b1, 10'h042, 1'b1, 1'b0);
        tick(); drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("trap_misalign", {31'd0, misalign}, 32'd1);
        chk("trap_target", 32'(trap_target), 32'h042);
        chk("trap_pc", 32'(pc), 32'h030);
        chk("trap_instret", instret, 32'd13);
        chk("trap_req", {31'd0, imem_bus.imem_req_o}, 32'd0);
        tick(); resume = 1'b0;
        chk("trap_resume_ignored", {31'd0, misalign}, 32'd1);
        chk("trap_valid", {31'd0, instr_valid}, 32'd0);
        chk("trap_pc_hold", 32'(pc), 32'h030);
        rst_n = 1'b0;
        #1;
        chk("rst_clears_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_clears_trap_target", 32'(trap_target), 32'd0);
        rst_n = 1'b1;

        // Memory backpressure, then async reset mid-wait.
        tick(); expect_fetch(10'h000, 0);
        tick(); expect_fetch(10'h004, 1);
        tick(); drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        #1 chk("bp_valid", {31'd0, instr_valid}, 32'd0);
        chk("bp_req", {31'd0, imem_bus.imem_req_o}, 32'd1);
        tick(); chk("bp_pc_hold1", 32'(pc), 32'h008);
        tick(); chk("bp_pc_hold2", 32'(pc), 32'h008);
        chk("bp_instret_hold", instret, 32'd2);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_pc", 32'(pc), 32'h0);
        chk("async_rst_instret", instret, 32'd0);
        rst_n = 1'b1;
        imem_bus.imem_ready_i = 1'b1;
        tick(); expect_fetch(10'h000, 0);
        tick(); expect_fetch(10'h004, 1);
        tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
